// File: rtl/ds_pkg.sv
// ds_pkg: shared widths, default destination base and FSM state encodings for the downsampler
package ds_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] DST_BASE_DEF = 32'h0001_0000;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_REQ = 3'd1;
    localparam logic [2:0] S_WR_REQ = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
endpackage

// File: rtl/ds_addr_gen.sv
// ds_addr_gen: row/col walker producing source and destination word addresses for 2:1 downsampling
module ds_addr_gen
    import ds_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter logic [ADDR_W-1:0] DST_BASE = DST_BASE_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clr,
    input  logic              advance,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last
);
    localparam int CW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
    localparam int RW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W / 2 - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H / 2 - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] src_row_base;
    logic              col_end;
    logic              row_end;

    assign col_end  = col == COL_MAX;
    assign row_end  = row == ROW_MAX;
    assign last     = col_end && row_end;
    assign src_addr = src_row_base + (ADDR_W'(col) << 1);
    assign dst_addr = DST_BASE + ADDR_W'(row) * ADDR_W'(IMG_W / 2) + ADDR_W'(col);

    // step col, wrapping into the next retained source row; src_row_base tracks 2*row*IMG_W
    always_ff @(posedge clock) begin
        if (rst || clr) begin
            col          <= '0;
            row          <= '0;
            src_row_base <= '0;
        end else if (advance) begin
            if (!col_end) begin
                col <= col + CW'(1);
            end else begin
                col <= '0;
                if (!row_end) begin
                    row          <= row + RW'(1);
                    src_row_base <= src_row_base + ADDR_W'(2 * IMG_W);
                end
            end
        end
    end
endmodule

// File: rtl/ds_seq_ctrl.sv
// ds_seq_ctrl: frame sequencer issuing read/write pairs per retained pixel and driving the pixel counter
module ds_seq_ctrl
    import ds_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter logic [ADDR_W-1:0] DST_BASE = DST_BASE_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cnt_rst,
    output logic              cnt_inc
);
    logic [2:0]        state;
    logic              fin;
    logic              clr;
    logic              advance;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              last;

    // indices clear when a frame is accepted and step as each write completes,
    // so the next source address is already valid during NEXT
    assign clr     = state == S_IDLE && start;
    assign advance = state == S_WR_REQ && mem_ack;

    ds_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .DST_BASE(DST_BASE)
    ) u_addr_gen (
        .clock   (clock),
        .rst     (rst),
        .clr     (clr),
        .advance (advance),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .last    (last)
    );

    // FSM with registered outputs; mem_wdata doubles as the read-data register
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= S_IDLE;
            fin       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt_rst   <= 1'b0;
            cnt_inc   <= 1'b0;
        end else begin
            cnt_rst <= 1'b0;
            cnt_inc <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_RD_REQ;
                    busy    <= 1'b1;
                    cnt_rst <= 1'b1;
                end
                S_RD_REQ: if (!mem_req) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= src_addr;
                end else if (mem_ack) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= dst_addr;
                    mem_wdata <= mem_rdata;
                    state     <= S_WR_REQ;
                end
                S_WR_REQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    cnt_inc <= 1'b1;
                    fin     <= last;
                    state   <= S_NEXT;
                end
                S_NEXT: if (fin) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end else begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= src_addr;
                    state    <= S_RD_REQ;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
